// File: rtl/adc_scan_sched.sv
// adc_scan_sched
//   Conversion scheduler for the two-channel ADC SPI engine. Every PERIOD_CYC
//   clocks it scans ch0 (heater thermistor) then ch1 (heatsink), each through a
//   conv_start/conv_done handshake, stores both results and drives heat_on with
//   hysteresis, a heatsink over-limit interlock and a conversion timeout fail-safe.
// Ports
//   clk48mhz, rstn          : clock, async active-low reset
//   enable                  : scanning and heating allowed
//   conv_start/conv_chsel   : start pulse and channel to the ADC engine
//   conv_done/conv_data     : completion pulse and result from the engine
//   setpoint, hs_limit      : ch0 target code, ch1 maximum code
//   clr_err                 : clears the sticky flags
//   ch0/ch1_value/_valid    : last results and loaded-since-reset flags
//   heat_on                 : heater drive
//   hs_fault, timeout_err,
//   overrun                 : sticky error flags
//   scan_count              : completed scans (wrapping)
module adc_scan_sched #(
    parameter int unsigned PERIOD_CYC  = 48000,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [15:0] HYST        = 16'h0100
) (
    input  logic        clk48mhz,
    input  logic        rstn,
    input  logic        enable,
    output logic        conv_start,
    output logic        conv_chsel,
    input  logic        conv_done,
    input  logic [15:0] conv_data,
    input  logic [15:0] setpoint,
    input  logic [15:0] hs_limit,
    input  logic        clr_err,
    output logic [15:0] ch0_value,
    output logic [15:0] ch1_value,
    output logic        ch0_valid,
    output logic        ch1_valid,
    output logic        heat_on,
    output logic        hs_fault,
    output logic        timeout_err,
    output logic        overrun,
    output logic [15:0] scan_count
);

    localparam int PW = (PERIOD_CYC  > 2) ? $clog2(PERIOD_CYC)  : 1;
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_STORE} state_t;

    state_t      state_q, state_d;
    logic [PW-1:0] per_q, per_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0] data_q, data_d;
    logic        start_q, start_d;
    logic        chsel_q, chsel_d;
    logic [15:0] ch0_q, ch0_d, ch1_q, ch1_d;
    logic        v0_q, v0_d, v1_q, v1_d;
    logic        heat_q, heat_d;
    logic        hsf_q, hsf_d, tmo_err_q, tmo_err_d, ovr_q, ovr_d;
    logic [15:0] scan_q, scan_d;

    logic        tick, hs_set, tmo_set, ovr_set;
    logic [15:0] lo;

    always_comb begin
        state_d  = state_q;
        per_d    = per_q;
        tmo_d    = tmo_q;
        data_d   = data_q;
        start_d  = 1'b0;
        chsel_d  = chsel_q;
        ch0_d    = ch0_q;
        ch1_d    = ch1_q;
        v0_d     = v0_q;
        v1_d     = v1_q;
        heat_d   = heat_q;
        scan_d   = scan_q;
        hs_set   = 1'b0;
        tmo_set  = 1'b0;

        // Counter parks at 0 while disabled so enabling gives an immediate tick.
        if (!enable)
            per_d = '0;
        else if (per_q == PW'(PERIOD_CYC - 1))
            per_d = '0;
        else
            per_d = per_q + 1'b1;

        tick    = enable && (per_q == '0);
        ovr_set = tick && (state_q != S_IDLE);
        lo      = (setpoint >= HYST) ? (setpoint - HYST) : 16'h0000;

        if (!enable) begin
            // Abandon any scan; a late conv_done lands in IDLE and is ignored.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        state_d = S_START;
                        chsel_d = 1'b0;
                        start_d = 1'b1;
                    end
                end
                S_START: begin
                    state_d = S_WAIT;
                    tmo_d   = '0;
                end
                S_WAIT: begin
                    if (conv_done) begin
                        data_d  = conv_data;
                        state_d = S_STORE;
                    end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                        tmo_set = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                S_STORE: begin
                    if (!chsel_q) begin
                        ch0_d = data_q;
                        v0_d  = 1'b1;
                        if (data_q < lo)
                            heat_d = 1'b1;
                        else if (data_q >= setpoint)
                            heat_d = 1'b0;
                        state_d = S_START;
                        chsel_d = 1'b1;
                        start_d = 1'b1;
                    end else begin
                        ch1_d   = data_q;
                        v1_d    = 1'b1;
                        hs_set  = (data_q > hs_limit);
                        scan_d  = scan_q + 16'd1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A set event in the same cycle beats clr_err.
        hsf_d     = hs_set  ? 1'b1 : (clr_err ? 1'b0 : hsf_q);
        tmo_err_d = tmo_set ? 1'b1 : (clr_err ? 1'b0 : tmo_err_q);
        ovr_d     = ovr_set ? 1'b1 : (clr_err ? 1'b0 : ovr_q);

        // Fail-safe overrides the hysteresis rules, including on the cycle the
        // cause is first registered. Clearing a cause does not re-enable heat;
        // only a later ch0 store can.
        if (hs_set || hsf_q || tmo_set || tmo_err_q || !enable)
            heat_d = 1'b0;
    end

    always_ff @(posedge clk48mhz or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            per_q     <= '0;
            tmo_q     <= '0;
            data_q    <= '0;
            start_q   <= 1'b0;
            chsel_q   <= 1'b0;
            ch0_q     <= '0;
            ch1_q     <= '0;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            heat_q    <= 1'b0;
            hsf_q     <= 1'b0;
            tmo_err_q <= 1'b0;
            ovr_q     <= 1'b0;
            scan_q    <= '0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            start_q   <= start_d;
            chsel_q   <= chsel_d;
            ch0_q     <= ch0_d;
            ch1_q     <= ch1_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            heat_q    <= heat_d;
            hsf_q     <= hsf_d;
            tmo_err_q <= tmo_err_d;
            ovr_q     <= ovr_d;
            scan_q    <= scan_d;
        end
    end

    assign conv_start  = start_q;
    assign conv_chsel  = chsel_q;
    assign ch0_value   = ch0_q;
    assign ch1_value   = ch1_q;
    assign ch0_valid   = v0_q;
    assign ch1_valid   = v1_q;
    assign heat_on     = heat_q;
    assign hs_fault    = hsf_q;
    assign timeout_err = tmo_err_q;
    assign overrun     = ovr_q;
    assign scan_count  = scan_q;

endmodule
